bist_controller: RTL
====================

BIST_CONTROLLER -- requirements
Module: bist_controller

Interface
REQ-001 The block SHALL have these parameters:
- CHAIN_LEN, 7, number of flops in the controlled scan chain.
- PATTERNS, 32, number of pseudo-random patterns applied per run.
- SEED, 16'hACE1, LFSR load value at run start; nonzero.
REQ-002 The block SHALL have these ports:
- clock  input  1  single clock for all state.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle request to begin a run; ignored while busy=1.
- abort  input  1  terminates a run in progress.
- golden  input  16  expected signature, sampled in DRAIN.
- chain_out  input  1  registered serial output of the scan chain.
- chain_in  output  1  serial data to the scan chain.
- test_control  output  1  1 = chain shifts, 0 = chain holds/captures.
- chain_reset  output  1  active-high synchronous clear for the chain.
- busy  output  1  run in progress.
- done  output  1  run complete; sticky until next accepted start.
- pass  output  1  signature matched golden; valid when done=1.
- signature  output  16  current MISR contents.

Function
REQ-003 FSM states SHALL be IDLE, INIT, SHIFT, CAPTURE, FLUSH, DRAIN and DONE; busy=1 in every state except IDLE and DONE.
REQ-004 IDLE/DONE with start=1 SHALL go to INIT; in all other states start SHALL have no effect.
REQ-005 INIT SHALL last 1 cycle and do all of the following:
- chain_reset=1, test_control=0.
- LFSR <= SEED, MISR <= 0.
- Bit and pattern counters <= 0.
- done <= 0, pass <= 0.
- Next state: SHIFT.
REQ-006 SHIFT SHALL last CHAIN_LEN cycles with the following behaviour:
- test_control=1, chain_in=LFSR[0].
- LFSR advances every cycle.
- Bit counter counts 0..CHAIN_LEN-1, then next state is CAPTURE.
REQ-007 CAPTURE SHALL last 1 cycle with test_control=0 and chain_in=0, then:
- Increment the pattern counter.
- Go to SHIFT if the counter is below PATTERNS, else to FLUSH.
REQ-008 FLUSH SHALL last CHAIN_LEN cycles with test_control=1, chain_in=0 and the LFSR frozen, then go to DRAIN.
REQ-009 DRAIN SHALL last 1 cycle with test_control=0, then go to DONE.
REQ-010 In DONE the block SHALL hold done=1 with test_control=0.
REQ-011 LFSR SHALL be a 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1:
- Shift right.
- New bit15 = bit0^bit2^bit3^bit5.
REQ-012 MISR SHALL use the same polynomial and update only in cycles where the previous cycle had test_control=1 (a registered copy of test_control):
- misr <= {fb, misr[15:1]} ^ {15'b0, chain_out}.
- fb = misr[0]^misr[2]^misr[3]^misr[5].
- The MISR updates in DRAIN but not in INIT.
REQ-013 In DRAIN, pass SHALL be set to (MISR next value == golden), registered, so pass becomes visible together with done=1.
REQ-014 Run length SHALL be fixed:
- done rises exactly 1 + PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 1 clocks after the edge that samples start.
- With defaults this is 265.
REQ-015 abort=1 in any busy state SHALL force IDLE on the next edge:
- test_control=0, done=0, pass=0.
- MISR is retained.
- abort has priority over every FSM transition.
REQ-016 abort in IDLE or DONE SHALL have no effect.
REQ-017 test_control, chain_in and chain_reset SHALL be registered outputs, free of glitches and of combinational paths from inputs.
REQ-018 Counters SHALL be sized to hold CHAIN_LEN and PATTERNS without wrap; the bit counter SHALL reset to 0 on every SHIFT entry.

Reset
REQ-019 With reset=0, all state SHALL clear asynchronously:
- FSM=IDLE.
- test_control=0, chain_in=0, chain_reset=0, busy=0, done=0, pass=0.
- LFSR=SEED, MISR=0, counters=0.
REQ-020 Reset asserted mid-run SHALL abandon the run with no completion indication.
REQ-021 The block SHALL leave reset state on the first clock edge after reset deasserts.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset, then one start pulse with defaults -> chain_reset high for 1 cycle; test_control high 7 cycles, low 1, repeated 32 times; 7 flush cycles; done=1 at cycle 265.
- Golden value from a bit-accurate model of LFSR, 7-flop chain and MISR -> pass=1, signature equals golden.
- Golden value with bit 0 flipped -> done=1, pass=0.
- abort asserted at cycle 100 -> IDLE next cycle; test_control=0, busy=0, done never rises; a later start runs a full 265 cycles.
- start pulsed at cycles 10 and 50 of a run -> no effect; run still ends at cycle 265.
- reset=0 at cycle 40 -> all outputs cleared immediately without waiting for a clock edge; after release, a fresh run produces the same signature as the first run.

Source files
------------

// File: rtl/bist_controller.sv
// Logic BIST sequencer: drives an LFSR-fed scan chain for a fixed number of
// patterns, compacts chain_out into a MISR and compares against a golden value.
module bist_controller #(
  parameter int unsigned CHAIN_LEN = 7,
  parameter int unsigned PATTERNS  = 32,
  parameter logic [15:0] SEED      = 16'hACE1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        abort,
  input  logic [15:0] golden,
  input  logic        chain_out,
  output logic        chain_in,
  output logic        test_control,
  output logic        chain_reset,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam int unsigned BIT_W = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PAT_W = $clog2(PATTERNS + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_INIT    = 3'd1,
    S_SHIFT   = 3'd2,
    S_CAPTURE = 3'd3,
    S_FLUSH   = 3'd4,
    S_DRAIN   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t           r_state, w_next_state;
  logic [BIT_W-1:0] r_bit_cnt;
  logic [PAT_W-1:0] r_pat_cnt;
  logic [15:0]      r_lfsr, r_misr, w_lfsr_d, w_misr_d;
  logic             r_tc_q;
  logic             r_tc, r_ci, r_crst, r_busy, r_done, r_pass;
  logic             w_tc, w_ci, w_crst, w_busy, w_done, w_pass;
  logic             w_busy_state, w_last_bit, w_pat_last;

  assign w_busy_state = (r_state != S_IDLE) && (r_state != S_DONE);
  assign w_last_bit   = (r_bit_cnt == BIT_W'(CHAIN_LEN - 1));
  assign w_pat_last   = ((r_pat_cnt + PAT_W'(1)) >= PAT_W'(PATTERNS));

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic; abort overrides every transition while busy
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (start) w_next_state = S_INIT;
      S_INIT:         w_next_state = S_SHIFT;
      S_SHIFT:        if (w_last_bit) w_next_state = S_CAPTURE;
      S_CAPTURE:      w_next_state = w_pat_last ? S_FLUSH : S_SHIFT;
      S_FLUSH:        if (w_last_bit) w_next_state = S_DRAIN;
      S_DRAIN:        w_next_state = S_DONE;
      default:        w_next_state = S_IDLE;
    endcase
    if (abort && w_busy_state) w_next_state = S_IDLE;
  end

  // LFSR/MISR next values; the MISR absorbs chain_out one cycle after each shift
  always_comb begin
    w_lfsr_d = r_lfsr;
    w_misr_d = r_misr;
    if (!(abort && w_busy_state)) begin
      if (r_state == S_INIT) begin
        w_lfsr_d = SEED;
        w_misr_d = 16'h0000;
      end else begin
        if (r_state == S_SHIFT)
          w_lfsr_d = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
        if (r_tc_q && w_busy_state)
          w_misr_d = {r_misr[0] ^ r_misr[2] ^ r_misr[3] ^ r_misr[5], r_misr[15:1]}
                     ^ {15'b0, chain_out};
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr    <= SEED;
      r_misr    <= 16'h0000;
      r_tc_q    <= 1'b0;
      r_bit_cnt <= '0;
      r_pat_cnt <= '0;
    end else begin
      r_lfsr <= w_lfsr_d;
      r_misr <= w_misr_d;
      r_tc_q <= r_tc;
      if ((r_state == S_SHIFT || r_state == S_FLUSH) && w_next_state == r_state)
        r_bit_cnt <= r_bit_cnt + BIT_W'(1);
      else
        r_bit_cnt <= '0;
      if (r_state == S_INIT)
        r_pat_cnt <= '0;
      else if (r_state == S_CAPTURE && w_next_state != S_IDLE)
        r_pat_cnt <= r_pat_cnt + PAT_W'(1);
    end
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    w_tc   = 1'b0;
    w_ci   = 1'b0;
    w_crst = 1'b0;
    w_busy = 1'b0;
    w_done = 1'b0;
    w_pass = 1'b0;
    case (w_next_state)
      S_INIT:    begin w_crst = 1'b1; w_busy = 1'b1; end
      S_SHIFT:   begin w_tc = 1'b1; w_ci = w_lfsr_d[0]; w_busy = 1'b1; end
      S_CAPTURE: w_busy = 1'b1;
      S_FLUSH:   begin w_tc = 1'b1; w_busy = 1'b1; end
      S_DRAIN:   w_busy = 1'b1;
      S_DONE: begin
        w_done = 1'b1;
        w_pass = (r_state == S_DRAIN) ? (w_misr_d == golden) : r_pass;
      end
      default:   w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tc   <= 1'b0;
      r_ci   <= 1'b0;
      r_crst <= 1'b0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_pass <= 1'b0;
    end else begin
      r_tc   <= w_tc;
      r_ci   <= w_ci;
      r_crst <= w_crst;
      r_busy <= w_busy;
      r_done <= w_done;
      r_pass <= w_pass;
    end
  end

  assign test_control = r_tc;
  assign chain_in     = r_ci;
  assign chain_reset  = r_crst;
  assign busy         = r_busy;
  assign done         = r_done;
  assign pass         = r_pass;
  assign signature    = r_misr;

endmodule
